pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Parametrised, handshaked pipeline register that replaces the fixed if_id / id_ex / ex_mem / mem_wb latches in the core. It carries an opaque payload bus (PC, instruction, decoded fields, ALU results) between two stages using valid/ready flow control, synchronous flush and an optional 2-entry skid buffer. This gives full throughput under back-pressure without a combinational ready path. It also provides a saturating stall counter for performance debug.

Parameters:
DATA_W, 64, payload width in bits (>=1)
SKID_EN, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
RST_VAL, 0, value loaded into data registers on reset (DATA_W bits)
CNT_W, 16, stall counter width (>=1)

Ports:
clk  input  1  clock, all logic rising-edge
rst_n  input  1  reset, synchronous, active-low
flush_i  input  1  synchronous flush: drop every held and incoming entry
in_valid_i  input  1  upstream payload valid
in_ready_o  output  1  stage can accept this cycle
in_data_i  input  DATA_W  upstream payload
out_valid_o  output  1  payload available downstream
out_ready_i  input  1  downstream accepts
out_data_o  output  DATA_W  payload to downstream stage
stall_cnt_o  output  CNT_W  saturating count of back-pressured cycles
stall_clr_i  input  1  synchronous clear of stall_cnt_o

Behaviour:
- Reset is one clock, a synchronous active-low rst_n; this is fixed. Sampled at posedge.
- Reset values: out_valid_o=0, out_data_o=RST_VAL, stall_cnt_o=0, skid data=RST_VAL. in_ready_o=0 while rst_n=0, and 1 in the first cycle after release.
- Handshake: in_xfer = in_valid_i & in_ready_o; out_xfer = out_valid_o & out_ready_i. Upstream must hold in_data_i stable while in_valid_i=1 & in_ready_o=0. Stage holds out_data_o stable while out_valid_o=1 & out_ready_i=0.
- Internal regs: main (valid, data) drives out_*; skid (valid, data) is present only if SKID_EN=1.
- SKID_EN=1 FSM, state = {main_v, skid_v}. in_ready_o = !skid_v, registered, with no path from out_ready_i.
  EMPTY(00): in_xfer -> HALF, main<=in_data_i.
  HALF(10): in_xfer & out_xfer -> HALF, main<=in_data_i. in_xfer & !out_xfer -> FULL, skid<=in_data_i. !in_xfer & out_xfer -> EMPTY. Otherwise hold.
  FULL(11): in_ready_o=0. out_xfer -> HALF, main<=skid. Otherwise hold. Skid is never overwritten while valid.
  Illegal 01 -> EMPTY next cycle.
- SKID_EN=0: in_ready_o = !main_v | out_ready_i, combinational. On in_xfer, main<=in_data_i and main_v=1. On out_xfer & !in_xfer, main_v=0.
- Latency: 1 cycle from in_xfer to out_valid_o when empty. Throughput: 1 beat/cycle with out_ready_i=1 (both modes).
- Ordering: strictly FIFO. No beat is dropped or duplicated except by flush.
- flush_i=1: next cycle main_v=skid_v=0, i.e. EMPTY. An in_xfer in the flush cycle is discarded. The out_xfer in the flush cycle still counts, since downstream already sampled it. Data regs are not cleared. in_ready_o=1 in the cycle after a flush.
- Priority: rst_n=0 > flush_i > normal update.
- Stall counter:
  - Increments when out_valid_o & !out_ready_i.
  - Saturates at 2^CNT_W-1, with no wrap.
  - stall_clr_i zeroes it, taking priority over increment.
  - Unaffected by flush.
- Reset mid-operation: all entries lost, and outputs go to reset values the next cycle.

Decomposition:
- Shared package (core_pkg): state encodings ST_EMPTY=2'b00, ST_HALF=2'b10, ST_FULL=2'b11, and default DATA_W constants per pipeline boundary (IF_ID_W, ID_EX_W, EX_MEM_W, MEM_WB_W).
- One sub-module: pipe_sat_cnt (parametrised CNT_W saturating counter with inc/clr), reused by other perf counters.
- FSM and datapath stay in pipe_stage_reg.

Test Plan:
- Reset then stream, SKID_EN=1, DATA_W=32, out_ready_i=1: in_data 0x1..0x8 on consecutive cycles -> out_valid_o 1 cycle later each, out_data 0x1..0x8 in order, in_ready_o stays 1.
- Back-pressure: send 0xA, 0xB, 0xC with out_ready_i=0 -> FULL after 0xB, in_ready_o=0, 0xC held. Then out_ready_i=1 -> outputs 0xA, 0xB, 0xC in order; stall_cnt_o equals the low-ready cycles with out_valid_o=1.
- Flush in FULL, holding 0x11/0x22, with in_valid=1 data 0x33 -> next cycle out_valid_o=0, in_ready_o=1. 0x11, 0x22 and 0x33 never appear at the output.
- SKID_EN=0 pass-through: out_ready_i toggles 1,0,1,0 with continuous input 0x100.. -> in_ready_o follows out_ready_i combinationally when full. No loss, correct order.
- Saturation: CNT_W=4, 20 stalled cycles -> stall_cnt_o=15. stall_clr_i pulse -> 0 the next cycle.
- Reset mid-stream: rst_n=0 for 1 cycle while in HALF with 0x55 -> out_valid_o=0, out_data_o=RST_VAL, in_ready_o=0 during reset and 1 after.

Source files
------------

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared pipeline-stage state encodings and boundary widths
package core_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BAD   = 2'b01,
        ST_HALF  = 2'b10,
        ST_FULL  = 2'b11
    } stage_state_t;

    localparam int IF_ID_W  = 64;
    localparam int ID_EX_W  = 160;
    localparam int EX_MEM_W = 128;
    localparam int MEM_WB_W = 96;

endpackage

// File: rtl/pipe_sat_cnt.sv
// rtl/pipe_sat_cnt.sv - saturating up-counter with synchronous clear
module pipe_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // clear wins over increment so a pulse during a stall still reads zero next
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - handshaked pipeline register with optional skid entry
module pipe_stage_reg
    import core_pkg::*;
#(
    parameter int                DATA_W  = 64,
    parameter bit                SKID_EN = 1'b1,
    parameter logic [DATA_W-1:0] RST_VAL = '0,
    parameter int                CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    input  logic              stall_clr_i
);

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = in_valid_i & in_ready_o;
    assign out_xfer = out_valid_o & out_ready_i;

    generate
        if (SKID_EN) begin : g_skid
            stage_state_t      state;
            logic [DATA_W-1:0] main_d;
            logic [DATA_W-1:0] skid_d;

            // ready comes straight from the skid-valid flop; rst_n only masks it
            assign in_ready_o  = rst_n & ~state[0];
            assign out_valid_o = state[1];
            assign out_data_o  = main_d;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    state  <= ST_EMPTY;
                    main_d <= RST_VAL;
                    skid_d <= RST_VAL;
                end else if (flush_i) begin
                    state <= ST_EMPTY;
                end else begin
                    case (state)
                        ST_EMPTY: begin
                            if (in_xfer) begin
                                state  <= ST_HALF;
                                main_d <= in_data_i;
                            end
                        end
                        ST_HALF: begin
                            if (in_xfer && out_xfer) begin
                                main_d <= in_data_i;
                            end else if (in_xfer) begin
                                state  <= ST_FULL;
                                skid_d <= in_data_i;
                            end else if (out_xfer) begin
                                state <= ST_EMPTY;
                            end
                        end
                        ST_FULL: begin
                            if (out_xfer) begin
                                state  <= ST_HALF;
                                main_d <= skid_d;
                            end
                        end
                        default: state <= ST_EMPTY;
                    endcase
                end
            end
        end else begin : g_single
            logic              main_v;
            logic [DATA_W-1:0] main_d;

            assign in_ready_o  = rst_n & (~main_v | out_ready_i);
            assign out_valid_o = main_v;
            assign out_data_o  = main_d;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    main_v <= 1'b0;
                    main_d <= RST_VAL;
                end else if (flush_i) begin
                    main_v <= 1'b0;
                end else if (in_xfer) begin
                    main_v <= 1'b1;
                    main_d <= in_data_i;
                end else if (out_xfer) begin
                    main_v <= 1'b0;
                end
            end
        end
    endgenerate

    pipe_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stall_clr_i),
        .inc   (out_valid_o & ~out_ready_i),
        .cnt   (stall_cnt_o)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - queue-model bench for skid and single-register stages
module tb_pipe_stage_reg;

    localparam logic [31:0] RV = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        stall_clr;

    logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic [31:0] out_data_a, out_data_b;
    logic [3:0]  stall_a;
    logic [15:0] stall_b;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] shown_a, shown_b;
    int          cnt_a_m, cnt_b_m;
    bit          blocked;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .SKID_EN(1'b1), .RST_VAL(RV), .CNT_W(4)) u_skid (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready_a), .in_data_i(in_data),
        .out_valid_o(out_valid_a), .out_ready_i(out_ready), .out_data_o(out_data_a),
        .stall_cnt_o(stall_a), .stall_clr_i(stall_clr)
    );

    pipe_stage_reg #(.DATA_W(32), .SKID_EN(1'b0), .RST_VAL(RV), .CNT_W(16)) u_pass (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready_b), .in_data_i(in_data),
        .out_valid_o(out_valid_b), .out_ready_i(out_ready), .out_data_o(out_data_b),
        .stall_cnt_o(stall_b), .stall_clr_i(stall_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, compare against the queue model, then advance it.
    task automatic step(input bit iv, input logic [31:0] d, input bit ordy,
                        input bit fl, input bit clr, input bit rn);
        bit ra, rb, ia, ib, oa, ob;
        @(negedge clk);
        in_valid = iv; in_data = d; out_ready = ordy;
        flush = fl; stall_clr = clr; rst_n = rn;
        #1;
        ra = rn && (qa.size() < 2);
        rb = rn && ((qb.size() == 0) || ordy);
        chk("a_in_ready",  32'(in_ready_a),  32'(ra));
        chk("a_out_valid", 32'(out_valid_a), 32'(qa.size() != 0));
        chk("a_out_data",  out_data_a,       shown_a);
        chk("a_stall_cnt", 32'(stall_a),     32'(cnt_a_m));
        chk("b_in_ready",  32'(in_ready_b),  32'(rb));
        chk("b_out_valid", 32'(out_valid_b), 32'(qb.size() != 0));
        chk("b_out_data",  out_data_b,       shown_b);
        chk("b_stall_cnt", 32'(stall_b),     32'(cnt_b_m));
        ia = iv && ra;
        ib = iv && rb;
        oa = (qa.size() != 0) && ordy;
        ob = (qb.size() != 0) && ordy;
        blocked = iv && !(ra && rb);
        @(posedge clk);
        if (!rn) begin
            qa.delete(); qb.delete();
            shown_a = RV; shown_b = RV;
            cnt_a_m = 0; cnt_b_m = 0;
        end else begin
            if (clr) cnt_a_m = 0;
            else if (qa.size() != 0 && !ordy && cnt_a_m < 15) cnt_a_m++;
            if (clr) cnt_b_m = 0;
            else if (qb.size() != 0 && !ordy && cnt_b_m < 65535) cnt_b_m++;
            if (fl) begin
                qa.delete(); qb.delete();
            end else begin
                if (oa) void'(qa.pop_front());
                if (ia) qa.push_back(d);
                if (ob) void'(qb.pop_front());
                if (ib) qb.push_back(d);
            end
            if (qa.size() != 0) shown_a = qa[0];
            if (qb.size() != 0) shown_b = qb[0];
        end
    endtask

    initial begin
        logic [31:0] rd;
        in_valid = 0; in_data = '0; out_ready = 0; flush = 0; stall_clr = 0; rst_n = 0;
        repeat (2) @(posedge clk);
        shown_a = RV; shown_b = RV; cnt_a_m = 0; cnt_b_m = 0;
        blocked = 0;

        step(0, 0, 0, 0, 0, 0);
        // streaming at full rate
        for (int i = 1; i <= 8; i++) step(1, 32'(i), 1, 0, 0, 1);
        repeat (3) step(0, 0, 1, 0, 0, 1);
        // back-pressure into FULL, then release
        step(0, 0, 1, 0, 1, 1);
        step(1, 32'hA, 0, 0, 0, 1);
        step(1, 32'hB, 0, 0, 0, 1);
        step(1, 32'hC, 0, 0, 0, 1);
        step(1, 32'hC, 0, 0, 0, 1);
        step(1, 32'hC, 1, 0, 0, 1);
        step(1, 32'hC, 1, 0, 0, 1);
        repeat (4) step(0, 0, 1, 0, 0, 1);
        // flush while FULL with a beat offered
        step(1, 32'h11, 0, 0, 0, 1);
        step(1, 32'h22, 0, 0, 0, 1);
        step(1, 32'h33, 0, 1, 0, 1);
        repeat (3) step(0, 0, 1, 0, 0, 1);
        // ready toggling with continuous input
        for (int i = 0; i < 10; i++) step(1, 32'h100 + 32'(i), (i % 2) == 0, 0, 0, 1);
        repeat (4) step(0, 0, 1, 0, 0, 1);
        // saturation of the 4-bit stall counter
        step(0, 0, 1, 0, 1, 1);
        step(1, 32'h77, 0, 0, 0, 1);
        repeat (20) step(0, 0, 0, 0, 0, 1);
        #1;
        chk("sat_cnt_a", 32'(stall_a), 32'd15);
        step(0, 0, 0, 0, 1, 1);
        #1;
        chk("clr_cnt_a", 32'(stall_a), 32'd0);
        repeat (3) step(0, 0, 1, 0, 0, 1);
        // reset while holding a beat
        step(1, 32'h55, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        repeat (2) step(0, 0, 1, 0, 0, 1);

        rd = $urandom;
        for (int i = 0; i < 400; i++) begin
            bit iv;
            iv = ($urandom_range(0, 3) != 0) || blocked;
            if (!blocked) rd = $urandom;
            step(iv, rd, $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0,
                 $urandom_range(0, 63) == 0, $urandom_range(0, 127) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
